mem_stage: RTL and testbench

Memory-access stage of the pipeline, directly downstream of the EX/MEM register. Consumes ALU result, store data and load/store/write-back control, performs the data-memory access over a req/ack handshake, and stalls the upstream stages while a transaction is outstanding. Registers the write-back result (load data or ALU result), destination register and write enable for the WB stage. Detects misaligned accesses and memory timeouts.

---
 rtl/mem_stage_if.sv | 22 ++
 rtl/mem_stage.sv | 131 +++++++++++++
 tb/tb_mem_stage.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
// rtl/mem_stage_if.sv - data-memory req/ack bus between the memory stage and data memory
`timescale 1ns/1ps
interface mem_stage_if #(
    parameter int DATA_WIDTH = 32
) ();
    logic                  DmemReq;
    logic                  DmemWe;
    logic [DATA_WIDTH-1:0] DmemAddr;
    logic [DATA_WIDTH-1:0] DmemWrData;
    logic                  DmemAck;
    logic [DATA_WIDTH-1:0] DmemRdData;

    modport master (
        output DmemReq, DmemWe, DmemAddr, DmemWrData,
        input  DmemAck, DmemRdData
    );

    modport slave (
        input  DmemReq, DmemWe, DmemAddr, DmemWrData,
        output DmemAck, DmemRdData
    );
endinterface

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - pipeline memory stage: data access over req/ack, stall, misalign/timeout errors
`timescale 1ns/1ps
module mem_stage #(
    parameter int DATA_WIDTH    = 32,
    parameter int REG_NUM_WIDTH = 5,
    parameter int TIMEOUT       = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_WIDTH-1:0]    ALUOutIn,
    input  logic [DATA_WIDTH-1:0]    RdDataBIn,
    input  logic                     IsLoadInsnIn,
    input  logic                     IsStoreInsnIn,
    input  logic                     RfWrEnableIn,
    input  logic [REG_NUM_WIDTH-1:0] WrNumIn,
    output logic                     Stall,
    mem_stage_if.master              dmem,
    output logic [DATA_WIDTH-1:0]    WbDataOut,
    output logic [REG_NUM_WIDTH-1:0] WbWrNumOut,
    output logic                     WbRfWrEnableOut,
    output logic                     MemErrOut
);
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                   r_state, w_next;
    logic [CW-1:0]            r_cnt;
    logic                     r_req, r_we;
    logic [DATA_WIDTH-1:0]    r_addr, r_wr_data;
    logic [REG_NUM_WIDTH-1:0] r_cap_num;
    logic                     r_cap_rf_we;
    logic [DATA_WIDTH-1:0]    r_wb_data;
    logic [REG_NUM_WIDTH-1:0] r_wb_num;
    logic                     r_wb_en, r_err;

    logic w_mem_insn, w_aligned, w_ack, w_timeout;

    assign w_mem_insn = IsLoadInsnIn | IsStoreInsnIn;
    assign w_aligned  = (ALUOutIn[1:0] == 2'b00);
    assign w_ack      = dmem.DmemAck;
    assign w_timeout  = (r_cnt == CNT_MAX);

    assign dmem.DmemReq    = r_req;
    assign dmem.DmemWe     = r_we;
    assign dmem.DmemAddr   = r_addr;
    assign dmem.DmemWrData = r_wr_data;
    assign WbDataOut       = r_wb_data;
    assign WbWrNumOut      = r_wb_num;
    assign WbRfWrEnableOut = r_wb_en;
    assign MemErrOut       = r_err;

    always_ff @(posedge clk) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    // Stall releases in the last BUSY cycle so upstream advances on the same edge we return to IDLE.
    always_comb begin
        w_next = r_state;
        Stall  = 1'b0;
        case (r_state)
            IDLE: if (w_mem_insn && w_aligned) begin
                Stall  = 1'b1;
                w_next = BUSY;
            end
            BUSY: if (w_ack || w_timeout) w_next = IDLE;
                  else                    Stall  = 1'b1;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt       <= '0;
            r_req       <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wr_data   <= '0;
            r_cap_num   <= '0;
            r_cap_rf_we <= 1'b0;
            r_wb_data   <= '0;
            r_wb_num    <= '0;
            r_wb_en     <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (!w_mem_insn) begin
                        r_wb_data <= ALUOutIn;
                        r_wb_num  <= WrNumIn;
                        r_wb_en   <= RfWrEnableIn;
                    end else if (!w_aligned) begin
                        r_wb_data <= ALUOutIn;
                        r_wb_num  <= WrNumIn;
                        r_wb_en   <= 1'b0;
                        r_err     <= 1'b1;
                    end else begin
                        // r_we doubles as the captured store flag; a load+store insn is a store.
                        r_req       <= 1'b1;
                        r_we        <= IsStoreInsnIn;
                        r_addr      <= ALUOutIn;
                        r_wr_data   <= RdDataBIn;
                        r_cap_num   <= WrNumIn;
                        r_cap_rf_we <= RfWrEnableIn;
                        r_cnt       <= '0;
                        r_wb_en     <= 1'b0;
                    end
                end
                BUSY: begin
                    if (w_ack) begin
                        r_req     <= 1'b0;
                        r_wb_data <= r_we ? r_addr : dmem.DmemRdData;
                        r_wb_num  <= r_cap_num;
                        r_wb_en   <= r_cap_rf_we & ~r_we;
                    end else if (w_timeout) begin
                        r_req   <= 1'b0;
                        r_wb_en <= 1'b0;
                        r_err   <= 1'b1;
                    end else begin
                        r_cnt   <= r_cnt + 1'b1;
                        r_wb_en <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed self-checking bench for mem_stage
`timescale 1ns/1ps
module tb_mem_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ALUOutIn, RdDataBIn;
    logic        IsLoadInsnIn, IsStoreInsnIn, RfWrEnableIn;
    logic [4:0]  WrNumIn;
    logic        Stall;
    logic [31:0] WbDataOut;
    logic [4:0]  WbWrNumOut;
    logic        WbRfWrEnableOut, MemErrOut;

    int n_checks = 0;
    int n_errors = 0;

    int          n_stall, n_req;
    logic        seen_we;
    logic [31:0] seen_addr, seen_wdata;

    mem_stage_if #(.DATA_WIDTH(32)) dmem_bus ();

    mem_stage #(.DATA_WIDTH(32), .REG_NUM_WIDTH(5), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .ALUOutIn(ALUOutIn), .RdDataBIn(RdDataBIn),
        .IsLoadInsnIn(IsLoadInsnIn), .IsStoreInsnIn(IsStoreInsnIn),
        .RfWrEnableIn(RfWrEnableIn), .WrNumIn(WrNumIn),
        .Stall(Stall), .dmem(dmem_bus),
        .WbDataOut(WbDataOut), .WbWrNumOut(WbWrNumOut),
        .WbRfWrEnableOut(WbRfWrEnableOut), .MemErrOut(MemErrOut)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_insn(input logic ld, input logic st, input logic [31:0] a,
                            input logic [31:0] d, input logic [4:0] rd, input logic we);
        IsLoadInsnIn  = ld;
        IsStoreInsnIn = st;
        ALUOutIn      = a;
        RdDataBIn     = d;
        WrNumIn       = rd;
        RfWrEnableIn  = we;
    endtask

    // Holds the current insn until Stall drops, acking on BUSY cycle ack_at (0 = never).
    task automatic mem_access(input int ack_at, input logic [31:0] rd_data);
        int  busy = 0;
        bit  done = 0;
        n_stall = 0;
        n_req   = 0;
        for (int k = 0; k < 40 && !done; k++) begin
            if (dmem_bus.DmemReq) begin
                busy++;
                seen_we    = dmem_bus.DmemWe;
                seen_addr  = dmem_bus.DmemAddr;
                seen_wdata = dmem_bus.DmemWrData;
            end
            dmem_bus.DmemAck    = (ack_at != 0 && busy == ack_at);
            dmem_bus.DmemRdData = rd_data;
            #1;
            if (Stall)            n_stall++;
            if (dmem_bus.DmemReq) n_req++;
            if (!Stall) done = 1;
            @(posedge clk);
            #1;
        end
        check("access_bound", 32'(done), 32'd1);
        dmem_bus.DmemAck = 1'b0;
        set_insn(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        set_insn(1'($urandom), 1'($urandom), $urandom, $urandom, 5'($urandom), 1'($urandom));
        dmem_bus.DmemAck    = 1'($urandom);
        dmem_bus.DmemRdData = $urandom;
        cycle();
        cycle();
        check("rst_req",    32'(dmem_bus.DmemReq), 32'd0);
        check("rst_we",     32'(dmem_bus.DmemWe), 32'd0);
        check("rst_addr",   dmem_bus.DmemAddr, 32'd0);
        check("rst_wdata",  dmem_bus.DmemWrData, 32'd0);
        check("rst_wbdata", WbDataOut, 32'd0);
        check("rst_wbnum",  32'(WbWrNumOut), 32'd0);
        check("rst_wben",   32'(WbRfWrEnableOut), 32'd0);
        check("rst_err",    32'(MemErrOut), 32'd0);
        set_insn(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0);
        dmem_bus.DmemAck = 1'b0;
        #1;
        check("rst_stall", 32'(Stall), 32'd0);
        rst = 1'b1;
        cycle();

        // ALU op
        set_insn(1'b0, 1'b0, 32'h1234, 32'h0, 5'd3, 1'b1);
        #1;
        check("alu_stall", 32'(Stall), 32'd0);
        cycle();
        check("alu_data", WbDataOut, 32'h1234);
        check("alu_num",  32'(WbWrNumOut), 32'd3);
        check("alu_en",   32'(WbRfWrEnableOut), 32'd1);
        check("alu_err",  32'(MemErrOut), 32'd0);

        // Load, ack on 4th BUSY cycle
        set_insn(1'b1, 1'b0, 32'h100, 32'h0, 5'd7, 1'b1);
        mem_access(4, 32'hDEADBEEF);
        check("ld_stall_cyc", 32'(n_stall), 32'd4);
        check("ld_req_cyc",   32'(n_req), 32'd4);
        check("ld_we",        32'(seen_we), 32'd0);
        check("ld_addr",      seen_addr, 32'h100);
        check("ld_data",      WbDataOut, 32'hDEADBEEF);
        check("ld_num",       32'(WbWrNumOut), 32'd7);
        check("ld_en",        32'(WbRfWrEnableOut), 32'd1);
        check("ld_err",       32'(MemErrOut), 32'd0);
        check("ld_req_after", 32'(dmem_bus.DmemReq), 32'd0);
        cycle();

        // Store, ack on first BUSY cycle
        set_insn(1'b0, 1'b1, 32'h40, 32'hA5A5A5A5, 5'd4, 1'b1);
        mem_access(1, 32'h0BADF00D);
        check("st_stall_cyc", 32'(n_stall), 32'd1);
        check("st_req_cyc",   32'(n_req), 32'd1);
        check("st_we",        32'(seen_we), 32'd1);
        check("st_wdata",     seen_wdata, 32'hA5A5A5A5);
        check("st_addr",      seen_addr, 32'h40);
        check("st_data",      WbDataOut, 32'h40);
        check("st_en",        32'(WbRfWrEnableOut), 32'd0);
        check("st_err",       32'(MemErrOut), 32'd0);
        cycle();

        // Load+store together behaves as store
        set_insn(1'b1, 1'b1, 32'h80, 32'h12345678, 5'd5, 1'b1);
        mem_access(1, 32'hFFFFFFFF);
        check("ldst_we",   32'(seen_we), 32'd1);
        check("ldst_data", WbDataOut, 32'h80);
        check("ldst_en",   32'(WbRfWrEnableOut), 32'd0);
        cycle();

        // Misaligned load
        set_insn(1'b1, 1'b0, 32'h102, 32'h0, 5'd9, 1'b1);
        mem_access(0, 32'h0);
        check("mis_stall_cyc", 32'(n_stall), 32'd0);
        check("mis_req_cyc",   32'(n_req), 32'd0);
        check("mis_err",       32'(MemErrOut), 32'd1);
        check("mis_en",        32'(WbRfWrEnableOut), 32'd0);
        check("mis_num",       32'(WbWrNumOut), 32'd9);
        check("mis_data",      WbDataOut, 32'h102);
        cycle();
        check("mis_err_pulse", 32'(MemErrOut), 32'd0);

        // Timeout: no ack
        set_insn(1'b1, 1'b0, 32'h200, 32'h0, 5'd10, 1'b1);
        mem_access(0, 32'h0);
        check("to_stall_cyc", 32'(n_stall), 32'd16);
        check("to_req_cyc",   32'(n_req), 32'd16);
        check("to_err",       32'(MemErrOut), 32'd1);
        check("to_en",        32'(WbRfWrEnableOut), 32'd0);
        check("to_req_after", 32'(dmem_bus.DmemReq), 32'd0);
        cycle();
        check("to_err_pulse", 32'(MemErrOut), 32'd0);

        // Ack on the 16th BUSY cycle wins over timeout
        set_insn(1'b1, 1'b0, 32'h204, 32'h0, 5'd11, 1'b1);
        mem_access(16, 32'h55AA55AA);
        check("ack16_stall_cyc", 32'(n_stall), 32'd16);
        check("ack16_req_cyc",   32'(n_req), 32'd16);
        check("ack16_err",       32'(MemErrOut), 32'd0);
        check("ack16_data",      WbDataOut, 32'h55AA55AA);
        check("ack16_en",        32'(WbRfWrEnableOut), 32'd1);
        cycle();

        // Reset mid-BUSY, then a late ack
        set_insn(1'b1, 1'b0, 32'h300, 32'h0, 5'd12, 1'b1);
        cycle();
        cycle();
        check("rb_req_busy", 32'(dmem_bus.DmemReq), 32'd1);
        rst = 1'b0;
        set_insn(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0);
        cycle();
        rst = 1'b1;
        dmem_bus.DmemAck    = 1'b1;
        dmem_bus.DmemRdData = 32'hCAFEF00D;
        #1;
        check("rb_req",   32'(dmem_bus.DmemReq), 32'd0);
        check("rb_stall", 32'(Stall), 32'd0);
        cycle();
        dmem_bus.DmemAck = 1'b0;
        check("rb_data", WbDataOut, 32'd0);
        check("rb_en",   32'(WbRfWrEnableOut), 32'd0);
        check("rb_err",  32'(MemErrOut), 32'd0);
        check("rb_req2", 32'(dmem_bus.DmemReq), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
